// File: rtl/rc5_pkg.sv
// rc5_pkg: definitions shared by the RC5 key expander and the encrypt core.
//   W, R          default word width and round count
//   T, W_BITS,    derived table size, rotate-amount width and S address
//   T_LENGTH      width for the default configuration
//   rc5State_t    IDLE / RUN / DONE control states
//   rotl          left rotate of a W-bit word
package rc5_pkg;

  localparam int unsigned W        = 32;
  localparam int unsigned R        = 12;
  localparam int unsigned T        = 2 * (R + 1);
  localparam int unsigned W_BITS   = $clog2(W);
  localparam int unsigned T_LENGTH = $clog2(T);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rc5State_t;

  // Concatenate the word with itself and shift: the top half is the rotation,
  // and an amount of 0 returns the word unchanged.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] value,
                                        input logic [W_BITS-1:0] amount);
    logic [2*W-1:0] doubled;
    doubled = {value, value} << amount;
    return doubled[2*W-1:W];
  endfunction

endpackage

// File: rtl/rc5_encrypt_core_if.sv
// rc5_encrypt_core_if: host-side request/result bundle of the RC5 encrypt core.
//   iStart, iPlainA, iPlainB      request and plaintext (host -> core)
//   oReady, oBusy, oDone          status (core -> host)
//   oCipherA, oCipherB            ciphertext (core -> host)
// master: host side, slave: core side.
interface rc5_encrypt_core_if #(
  parameter int unsigned W = rc5_pkg::W
);

  logic         iStart;
  logic [W-1:0] iPlainA;
  logic [W-1:0] iPlainB;
  logic         oReady;
  logic         oBusy;
  logic [W-1:0] oCipherA;
  logic [W-1:0] oCipherB;
  logic         oDone;

  modport master (
    output iStart, iPlainA, iPlainB,
    input  oReady, oBusy, oCipherA, oCipherB, oDone
  );

  modport slave (
    input  iStart, iPlainA, iPlainB,
    output oReady, oBusy, oCipherA, oCipherB, oDone
  );

endinterface

// File: rtl/rc5_half_round.sv
// rc5_half_round: one RC5 half-round, purely combinational.
//   bypass  1: result = x + s (pre-whitening steps k=0/1)
//           0: result = rotl(x ^ y, y[W_BITS-1:0]) + s
//   x, y    word being updated, and the other word
//   s       S table entry for this step
//   result  new value for x
module rc5_half_round #(
  parameter  int unsigned W      = rc5_pkg::W,
  localparam int unsigned W_BITS = $clog2(W)
) (
  input  logic         bypass,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] s,
  output logic [W-1:0] result
);

  logic [W-1:0]   mixed;
  logic [2*W-1:0] doubled;
  logic [W-1:0]   rotated;

  always_comb begin
    mixed   = x ^ y;
    doubled = {mixed, mixed} << y[W_BITS-1:0];
    rotated = doubled[2*W-1:W];
    result  = (bypass ? x : rotated) + s;
  end

endmodule

// File: rtl/rc5_encrypt_core.sv
// rc5_encrypt_core: encrypts one 2W-bit block (A,B) over R rounds using the
// expanded S table, reading one S word per cycle.
//   clk, rst      clock; synchronous active-high reset
//   iKeyReady     S table valid (level); falling during a run aborts it
//   oS_address    S memory read address (k while running, else 0)
//   iS_sub_i      S memory read data, valid in the same cycle as oS_address
//   host          request/plaintext in, ready/busy/done/ciphertext out
// Timing: start accepted at the end of cycle 0, T run cycles, oDone in cycle T+1.
module rc5_encrypt_core #(
  parameter  int unsigned W        = rc5_pkg::W,
  parameter  int unsigned R        = rc5_pkg::R,
  localparam int unsigned T        = 2 * (R + 1),
  localparam int unsigned T_LENGTH = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iKeyReady,
  output logic [T_LENGTH-1:0] oS_address,
  input  logic [W-1:0]        iS_sub_i,
  rc5_encrypt_core_if.slave   host
);

  import rc5_pkg::*;

  rc5State_t           state;
  rc5State_t           stateNext;
  logic [W-1:0]        regA;
  logic [W-1:0]        regB;
  logic [T_LENGTH-1:0] k;
  logic [W-1:0]        cipherA;
  logic [W-1:0]        cipherB;

  logic                kOdd;
  logic                lastK;
  logic                bypass;
  logic [W-1:0]        halfX;
  logic [W-1:0]        halfY;
  logic [W-1:0]        halfOut;
  logic                ready;
  logic                busy;
  logic                done;
  logic                accept;

  // Odd steps update B from the already-updated A; even steps update A from B.
  assign kOdd   = k[0];
  assign lastK  = (k == T_LENGTH'(T - 1));
  assign bypass = (k[T_LENGTH-1:1] == '0);
  assign halfX  = kOdd ? regB : regA;
  assign halfY  = kOdd ? regA : regB;
  assign accept = host.iStart && iKeyReady;

  rc5_half_round #(.W(W)) halfRound (
    .bypass (bypass),
    .x      (halfX),
    .y      (halfY),
    .s      (iS_sub_i),
    .result (halfOut)
  );

  always_comb begin
    stateNext  = state;
    oS_address = '0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = iKeyReady;
        if (accept) stateNext = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        oS_address = k;
        if (!iKeyReady)  stateNext = IDLE;
        else if (lastK)  stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      regA    <= '0;
      regB    <= '0;
      k       <= '0;
      cipherA <= '0;
      cipherB <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (accept) begin
            regA <= host.iPlainA;
            regB <= host.iPlainB;
            k    <= '0;
          end
        end
        RUN: begin
          if (!iKeyReady) begin
            k <= '0;
          end else begin
            if (kOdd) regB <= halfOut;
            else      regA <= halfOut;
            // The last step is always a B update, so the ciphertext is the
            // current A with the fresh B; loading it here makes it valid
            // exactly while oDone is high.
            if (lastK) begin
              k       <= '0;
              cipherA <= regA;
              cipherB <= halfOut;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign host.oReady   = ready;
  assign host.oBusy    = busy;
  assign host.oDone    = done;
  assign host.oCipherA = cipherA;
  assign host.oCipherB = cipherB;

endmodule

// File: tb/tb_rc5_encrypt_core.sv
module tb_rc5_encrypt_core;

  localparam int TBIG   = 26;
  localparam int TSMALL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic keyReady = 1'b0;

  logic [4:0]  addr12;
  logic [31:0] sub12;
  logic [1:0]  addr1;
  logic [31:0] sub1;

  logic [31:0] sMem [TBIG];
  logic [31:0] sMemSmall [TSMALL];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rc5_encrypt_core_if #(.W(32)) bus12 ();
  rc5_encrypt_core_if #(.W(32)) bus1 ();

  rc5_encrypt_core #(.W(32), .R(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .iKeyReady  (keyReady),
    .oS_address (addr12),
    .iS_sub_i   (sub12),
    .host       (bus12.slave)
  );

  rc5_encrypt_core #(.W(32), .R(1)) dutSmall (
    .clk        (clk),
    .rst        (rst),
    .iKeyReady  (keyReady),
    .oS_address (addr1),
    .iS_sub_i   (sub1),
    .host       (bus1.slave)
  );

  assign sub12 = (addr12 < 5'd26) ? sMem[addr12] : 32'hDEADBEEF;
  assign sub1  = sMemSmall[addr1];

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] v, input int unsigned n);
    int unsigned m;
    m = n % 32;
    if (m == 0) return v;
    return (v << m) | (v >> (32 - m));
  endfunction

  // Standard RC5 encryption over the 26-entry table in sMem, written per round.
  task automatic refEncrypt(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] ca, output logic [31:0] cb);
    a = a + sMem[0];
    b = b + sMem[1];
    for (int r = 1; r <= 12; r++) begin
      a = rol(a ^ b, b) + sMem[2*r];
      b = rol(b ^ a, a) + sMem[2*r+1];
    end
    ca = a;
    cb = b;
  endtask

  // RC5-32/12 key schedule for a 16-byte all-zero key.
  task automatic expandZeroKey();
    logic [31:0] l [4];
    logic [31:0] a;
    logic [31:0] b;
    int i;
    int j;
    for (int n = 0; n < 4; n++) l[n] = '0;
    sMem[0] = 32'hB7E15163;
    for (int n = 1; n < TBIG; n++) sMem[n] = sMem[n-1] + 32'h9E3779B9;
    a = '0; b = '0; i = 0; j = 0;
    for (int n = 0; n < 3 * TBIG; n++) begin
      a = rol(sMem[i] + a + b, 3);
      sMem[i] = a;
      b = rol(l[j] + a + b, a + b);
      l[j] = b;
      i = (i + 1) % TBIG;
      j = (j + 1) % 4;
    end
  endtask

  task automatic randomTable();
    for (int n = 0; n < TBIG; n++) sMem[n] = $urandom;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start on the R=12 core and observes 40 cycles; returns what it saw.
  task automatic runBlock(input logic [31:0] a, input logic [31:0] b,
                          output int latency, output logic [31:0] ca,
                          output logic [31:0] cb, output int doneCount,
                          output bit addrOk);
    bus12.iPlainA = a;
    bus12.iPlainB = b;
    bus12.iStart  = 1'b1;
    latency = -1; doneCount = 0; addrOk = 1'b1; ca = '0; cb = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      bus12.iStart = 1'b0;
      if (c <= TBIG && (bus12.oBusy !== 1'b1 || addr12 !== 5'(c - 1))) addrOk = 1'b0;
      if (c > TBIG && bus12.oBusy !== 1'b0) addrOk = 1'b0;
      if (bus12.oDone === 1'b1) begin
        doneCount++;
        if (latency < 0) begin
          latency = c;
          ca = bus12.oCipherA;
          cb = bus12.oCipherB;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; keyReady = 1'b0;
    bus12.iStart = 1'b0; bus12.iPlainA = '0; bus12.iPlainB = '0;
    bus1.iStart = 1'b0;  bus1.iPlainA = '0;  bus1.iPlainB = '0;
    repeat (3) tick();
    vectors++;
    if ({bus12.oBusy, bus12.oDone, bus12.oReady} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_status got busy/done/ready=%b expected 000",
               {bus12.oBusy, bus12.oDone, bus12.oReady});
    end
    vectors++;
    if (bus12.oCipherA !== 32'h0 || bus12.oCipherB !== 32'h0 || addr12 !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_data got A=%h B=%h addr=%0d expected 0 0 0",
               bus12.oCipherA, bus12.oCipherB, addr12);
    end
    rst = 1'b0;
    tick();
    keyReady = 1'b1;
    #1;
    vectors++;
    if (bus12.oReady !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_ready got %b expected 1", bus12.oReady);
    end
  endtask

  task automatic test_small_r1();
    logic [1:0] addrs [$];
    int latency;
    logic [31:0] ca, cb;
    for (int n = 0; n < TSMALL; n++) sMemSmall[n] = 32'(n);
    bus1.iPlainA = '0; bus1.iPlainB = '0; bus1.iStart = 1'b1;
    latency = -1; ca = '0; cb = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus1.iStart = 1'b0;
      if (bus1.oBusy === 1'b1) addrs.push_back(addr1);
      if (bus1.oDone === 1'b1 && latency < 0) begin
        latency = c; ca = bus1.oCipherA; cb = bus1.oCipherB;
      end
    end
    vectors++;
    if (latency != 5) begin
      miscompares++;
      $display("FAIL r1_latency got %0d expected 5", latency);
    end
    vectors++;
    if (ca !== 32'h00000004 || cb !== 32'h00000053) begin
      miscompares++;
      $display("FAIL r1_cipher got %h_%h expected 00000004_00000053", ca, cb);
    end
    vectors++;
    if (addrs.size() != 4 || addrs[0] !== 2'd0 || addrs[1] !== 2'd1 ||
        addrs[2] !== 2'd2 || addrs[3] !== 2'd3) begin
      miscompares++;
      $display("FAIL r1_addr_seq got %0d entries expected 0,1,2,3", addrs.size());
    end
  endtask

  task automatic test_zero_key();
    int latency, doneCount;
    logic [31:0] ca, cb;
    bit addrOk;
    expandZeroKey();
    runBlock(32'h0, 32'h0, latency, ca, cb, doneCount, addrOk);
    vectors++;
    if (latency != TBIG + 1) begin
      miscompares++;
      $display("FAIL zero_key_latency got %0d expected %0d", latency, TBIG + 1);
    end
    vectors++;
    if (ca !== 32'hEEDBA521 || cb !== 32'h6D8F4B15) begin
      miscompares++;
      $display("FAIL zero_key_cipher got %h_%h expected eedba521_6d8f4b15", ca, cb);
    end
    vectors++;
    if (!addrOk || doneCount != 1) begin
      miscompares++;
      $display("FAIL zero_key_addr_done got addrOk=%0d dones=%0d expected 1 1",
               addrOk, doneCount);
    end
  endtask

  task automatic test_random();
    int latency, doneCount;
    logic [31:0] a, b, ca, cb, ea, eb;
    bit addrOk;
    for (int n = 0; n < 5; n++) begin
      randomTable();
      a = $urandom; b = $urandom;
      if (n == 0) b = 32'h00000020; // rotate amount with low bits zero
      refEncrypt(a, b, ea, eb);
      runBlock(a, b, latency, ca, cb, doneCount, addrOk);
      vectors++;
      if (ca !== ea || cb !== eb || latency != TBIG + 1 || doneCount != 1) begin
        miscompares++;
        $display("FAIL random_%0d got %h_%h lat=%0d dones=%0d expected %h_%h lat=%0d dones=1",
                 n, ca, cb, latency, doneCount, ea, eb, TBIG + 1);
      end
    end
  endtask

  task automatic test_key_not_ready();
    logic [31:0] a, b, ea, eb;
    int latency;
    randomTable();
    a = $urandom; b = $urandom;
    refEncrypt(a, b, ea, eb);
    keyReady = 1'b0;
    bus12.iPlainA = a; bus12.iPlainB = b; bus12.iStart = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({bus12.oBusy, bus12.oDone, bus12.oReady} !== 3'b000) begin
        miscompares++;
        $display("FAIL nokey_cycle%0d got busy/done/ready=%b expected 000",
                 c, {bus12.oBusy, bus12.oDone, bus12.oReady});
      end
    end
    keyReady = 1'b1;
    #1;
    vectors++;
    if (bus12.oReady !== 1'b1) begin
      miscompares++;
      $display("FAIL nokey_ready_rise got %b expected 1", bus12.oReady);
    end
    tick();
    bus12.iStart = 1'b0;
    vectors++;
    if (bus12.oReady !== 1'b0 || bus12.oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL nokey_accept got ready=%b busy=%b expected 0 1",
               bus12.oReady, bus12.oBusy);
    end
    latency = -1;
    for (int c = 2; c <= 40 && latency < 0; c++) begin
      tick();
      if (bus12.oDone === 1'b1) latency = c;
    end
    vectors++;
    if (latency != TBIG + 1 || bus12.oCipherA !== ea || bus12.oCipherB !== eb) begin
      miscompares++;
      $display("FAIL nokey_result got %h_%h lat=%0d expected %h_%h lat=%0d",
               bus12.oCipherA, bus12.oCipherB, latency, ea, eb, TBIG + 1);
    end
    repeat (2) tick();
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b, ea, eb, ca, cb;
    int doneCount;
    randomTable();
    a = $urandom; b = $urandom;
    refEncrypt(a, b, ea, eb);
    bus12.iPlainA = a; bus12.iPlainB = b; bus12.iStart = 1'b1;
    doneCount = 0; ca = '0; cb = '0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      bus12.iStart = 1'b0;
      if (c == 5) begin
        bus12.iPlainA = ~a; bus12.iPlainB = b ^ 32'h1234_5678; bus12.iStart = 1'b1;
      end
      if (bus12.oDone === 1'b1) begin
        doneCount++;
        ca = bus12.oCipherA; cb = bus12.oCipherB;
      end
    end
    vectors++;
    if (doneCount != 1 || ca !== ea || cb !== eb) begin
      miscompares++;
      $display("FAIL start_ignored got dones=%0d %h_%h expected dones=1 %h_%h",
               doneCount, ca, cb, ea, eb);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, ea, eb, ca, cb;
    int latency, doneCount;
    bit addrOk;
    a = $urandom; b = $urandom;
    bus12.iPlainA = a; bus12.iPlainB = b; bus12.iStart = 1'b1;
    repeat (8) begin
      tick();
      bus12.iStart = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus12.oBusy !== 1'b0 || bus12.oDone !== 1'b0 || addr12 !== 5'd0 ||
        bus12.oCipherA !== 32'h0 || bus12.oCipherB !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid got busy=%b done=%b addr=%0d A=%h B=%h expected all 0",
               bus12.oBusy, bus12.oDone, addr12, bus12.oCipherA, bus12.oCipherB);
    end
    doneCount = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus12.oDone === 1'b1 || bus12.oBusy === 1'b1) doneCount++;
    end
    vectors++;
    if (doneCount != 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet got %0d active cycles expected 0", doneCount);
    end
    randomTable();
    refEncrypt(a, b, ea, eb);
    runBlock(a, b, latency, ca, cb, doneCount, addrOk);
    vectors++;
    if (ca !== ea || cb !== eb || latency != TBIG + 1) begin
      miscompares++;
      $display("FAIL reset_mid_fresh got %h_%h lat=%0d expected %h_%h lat=%0d",
               ca, cb, latency, ea, eb, TBIG + 1);
    end
  endtask

  task automatic test_abort();
    logic [31:0] prevA, prevB;
    int activity;
    prevA = bus12.oCipherA; prevB = bus12.oCipherB;
    bus12.iPlainA = $urandom; bus12.iPlainB = $urandom; bus12.iStart = 1'b1;
    repeat (6) begin
      tick();
      bus12.iStart = 1'b0;
    end
    keyReady = 1'b0;
    tick();
    vectors++;
    if (bus12.oBusy !== 1'b0 || bus12.oDone !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle got busy=%b done=%b expected 0 0", bus12.oBusy, bus12.oDone);
    end
    keyReady = 1'b1;
    activity = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus12.oDone === 1'b1 || bus12.oBusy === 1'b1) activity++;
    end
    vectors++;
    if (activity != 0 || bus12.oCipherA !== prevA || bus12.oCipherB !== prevB) begin
      miscompares++;
      $display("FAIL abort_hold got active=%0d %h_%h expected 0 %h_%h",
               activity, bus12.oCipherA, bus12.oCipherB, prevA, prevB);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [31:0] ea, eb;
    int doneAt [$];
    randomTable();
    for (int n = 0; n < 3; n++) begin
      pa[n] = $urandom; pb[n] = $urandom;
    end
    bus12.iPlainA = pa[0]; bus12.iPlainB = pb[0]; bus12.iStart = 1'b1;
    for (int c = 1; c <= 4 * (TBIG + 2) && doneAt.size() < 3; c++) begin
      tick();
      if (bus12.oDone === 1'b1) begin
        refEncrypt(pa[doneAt.size()], pb[doneAt.size()], ea, eb);
        vectors++;
        if (bus12.oCipherA !== ea || bus12.oCipherB !== eb) begin
          miscompares++;
          $display("FAIL b2b_result%0d got %h_%h expected %h_%h",
                   doneAt.size(), bus12.oCipherA, bus12.oCipherB, ea, eb);
        end
        doneAt.push_back(c);
        if (doneAt.size() < 3) begin
          bus12.iPlainA = pa[doneAt.size()]; bus12.iPlainB = pb[doneAt.size()];
        end else begin
          bus12.iStart = 1'b0;
        end
      end
    end
    bus12.iStart = 1'b0;
    vectors++;
    if (doneAt.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count got %0d dones expected 3", doneAt.size());
    end else begin
      for (int n = 1; n < 3; n++) begin
        vectors++;
        if (doneAt[n] - doneAt[n-1] != TBIG + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d got %0d expected %0d",
                   n, doneAt[n] - doneAt[n-1], TBIG + 2);
        end
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    for (int n = 0; n < TBIG; n++) sMem[n] = '0;
    for (int n = 0; n < TSMALL; n++) sMemSmall[n] = '0;
    test_reset();
    test_small_r1();
    test_zero_key();
    test_random();
    test_key_not_ready();
    test_start_ignored();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rc5_encrypt_core.md
Name: rc5_encrypt_core

Overview:
- Downstream consumer of the RC5 key expander.
- Once the expanded S table is complete, the block encrypts one 2W-bit plaintext block (A,B) per request over R rounds.
- It reads S[0..T-1] from the shared S memory one word per cycle.
- It sits between the key-expansion stage and the block-cipher datapath or host interface.

Parameters:
W, 32, word width in bits (A, B, S entries)
R, 12, number of rounds
T, 2*(R+1), number of S table entries (derived, not overridden)
W_BITS, $clog2(W), rotate-amount width (derived)
T_LENGTH, $clog2(T), S address width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
iKeyReady  in  1  S table valid; driven from oKeyExpanderDone, level
iStart  in  1  start request, sampled on rising edge of clk
iPlainA  in  W  plaintext word A (first/low word)
iPlainB  in  W  plaintext word B
oS_address  out  T_LENGTH  S memory read address
iS_sub_i  in  W  S memory read data, combinational (valid in same cycle as oS_address)
oReady  out  1  can accept iStart (IDLE and iKeyReady)
oBusy  out  1  encryption in progress
oCipherA  out  W  ciphertext word A
oCipherB  out  W  ciphertext word B
oDone  out  1  one-cycle pulse, ciphertext valid

Behaviour:
- Reset state: all outputs 0, state IDLE, internal A/B/k registers 0. The same applies if rst is asserted mid-operation: the block returns to IDLE next cycle and oDone is not issued.
- States: IDLE, RUN, DONE.
- IDLE: oReady = iKeyReady and oS_address = 0.
  - iStart && iKeyReady captures A<=iPlainA, B<=iPlainB and k<=0, then goes to RUN.
  - iStart without iKeyReady is ignored.
- RUN: oBusy=1 and oS_address=k. One half-operation is performed per cycle:
  - k=0: A<=A+S
  - k=1: B<=B+S
  - k even >=2: A<=rotl(A^B, B[W_BITS-1:0])+S
  - k odd >=3: B<=rotl(B^A, A[W_BITS-1:0])+S, where A is the already-registered updated value
  - k increments each cycle. At k=T-1, after the update, the block goes to DONE.
- DONE: lasts one cycle. oDone=1, oBusy=0, then the block returns to IDLE.
- Arithmetic:
  - Additions are mod 2^W with carry discarded.
  - Rotation is a left rotate by the low W_BITS bits of the other word; an amount of 0 leaves the word unchanged.
- oCipherA/oCipherB:
  - Registered; updated at the DONE cycle.
  - Held until the next DONE or reset. They do not track internal A/B during RUN.
- Latency: with the start accepted in cycle 0, oDone is high in cycle T+1. That is cycle 27 for R=12, and no new start can be accepted until cycle T+2.
- iStart during RUN/DONE is ignored; it is not queued.
- iKeyReady falling during RUN aborts: the block goes to IDLE next cycle with no oDone, and cipher outputs keep their previous value.
- Address wrap: k never exceeds T-1, and oS_address never presents an out-of-range value.

Decomposition:
- Shared package rc5_pkg holds:
  - W, R, T, W_BITS, T_LENGTH defaults
  - state encoding constants (IDLE, RUN, DONE)
  - rotl function
- The package is shared with the key-expander stages.
- One natural sub-module: rc5_half_round, purely combinational. Inputs x, y, s; output rotl(x^y, y[W_BITS-1:0])+s. It is instantiated once and muxed by k parity. k=0/1 bypass the xor/rotate path via a select input.

Test Plan:
1. R=1 (T=4), S model S[i]=i, plaintext A=0 B=0: oDone at cycle 5 after start; oCipherA=0x00000004, oCipherB=0x00000053; oS_address sequence 0,1,2,3.
2. R=12, S table from the key expander with key=all-zero 16 bytes, plaintext A=0 B=0: oCipherA=0xEEDBA521, oCipherB=0x6D8F4B15 (ciphertext bytes 21A5DBEE154B8F6D); oDone exactly 27 cycles after start.
3. iStart held high with iKeyReady=0 for 10 cycles: no state change, oBusy=0, oDone=0. Raise iKeyReady: start accepted next edge, and oReady goes low the cycle after.
4. Pulse iStart again at cycle 5 of a run with different plaintext: ignored; first result unaffected; exactly one oDone.
5. Assert rst at cycle 8 of a run: next cycle all outputs 0 and state IDLE; no oDone; fresh start afterwards gives the correct result.
6. Drop iKeyReady at cycle 6 of a run: abort to IDLE, no oDone, oCipherA/B retain the previous result. Back-to-back starts at the earliest oReady give oDone pulses spaced T+2 cycles apart.
